// File: rtl/arb_pkg.sv
// Shared definitions for the decoder grant arbiter.
//   state_t  : arbiter FSM states (IDLE, GRANTED, GAP)
//   NUM_REQ  : number of requesters (decoder outputs Y7..Y0)
//   IDX_W    : decoder address width (A, B, C)
//   CNT_W    : width of the optional hold counter
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    GAP     = 2'd2
  } state_t;

endpackage

// File: rtl/sel_decode_3to8.sv
// Purely combinational 3-to-8 decoder with enable, modelling the shared
// decode/select path driven by the arbiter.
// Ports:
//   a, b, c : address bits, output index is {a,b,c} (a is the MSB)
//   en      : enable; with en low every output is low
//   y[7:0]  : one-hot select, y = en ? (1 << {a,b,c}) : 8'h00
module sel_decode_3to8
  import arb_pkg::*;
(
  input  logic               a,
  input  logic               b,
  input  logic               c,
  input  logic               en,
  output logic [NUM_REQ-1:0] y
);

  logic [IDX_W-1:0] addr;

  assign addr = {a, b, c};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_out
      assign y[gi] = en && (addr == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/decoder_grant_arbiter.sv
// 8-way round-robin arbiter sharing one 3-to-8 decoded select.
// Drives the decoder address/enable and the resulting one-hot select, and
// guarantees at least one all-low select cycle after every release.
//
// Optional feature: define ARB_TIMEOUT_EN to add a hold counter that forces
// a release after HOLD_MAX cycles without done and pulses timeout.
//
// Parameters:
//   HOLD_MAX   : max grant length without done (timeout build only), 1..255
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous active-high reset
//   req[7:0]   : request vector, bit i = requester i
//   done       : release strobe from the current grantee
//   gnt_idx    : decoder address {A,B,C}
//   gnt_en     : decoder enable, high exactly while a grant is active
//   gnt_onehot : gnt_en ? (1 << gnt_idx) : 0
//   busy       : high in GRANTED (same as gnt_en)
//   timeout    : one-cycle pulse on the first GAP cycle after a forced release
module decoder_grant_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_en,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic               busy,
  output logic               timeout
);

  generate
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("HOLD_MAX must be in 1..255");
    end
  endgenerate

  // Round-robin winner: rotate req so that bit 0 holds requester ptr+1,
  // take the lowest set bit, then undo the rotation. The 3-bit adds wrap
  // modulo 8 by construction.
  function automatic logic [IDX_W-1:0] pick_winner(
    input logic [NUM_REQ-1:0] r,
    input logic [IDX_W-1:0]   p
  );
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     start;
    logic [IDX_W-1:0]     off;
    start = p + 1'b1;
    dbl   = {r, r};
    rot   = dbl[start +: NUM_REQ];
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    return start + off;
  endfunction

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] winner;
  logic             arb_win;
  logic             hold_expired;
  logic             release_now;

  assign winner = pick_winner(req, ptr_reg);

  // IDLE and GAP arbitrate identically; only the preceding history differs.
  assign arb_win = (state_reg != GRANTED) && (|req);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_reg;

  // cnt_reg counts completed GRANTED cycles, so the limit is reached while
  // the grant is in its HOLD_MAX-th cycle.
  assign hold_expired = (state_reg == GRANTED) && (cnt_reg == CNT_W'(HOLD_MAX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      // done wins over a coinciding limit: no pulse in that case.
      timeout_reg <= hold_expired && !done;
      if (arb_win) begin
        cnt_reg <= '0;
      end else if (state_reg == GRANTED && !release_now) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign timeout = timeout_reg;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign release_now = (state_reg == GRANTED) && (done || hold_expired);

  // State register and grant datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 3'd7;
      idx_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      if (arb_win) begin
        idx_reg <= winner;
        ptr_reg <= winner;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, GAP: begin
        state_next = (|req) ? GRANTED : IDLE;
      end
      GRANTED: begin
        if (release_now) state_next = GAP;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so they move on edges.
  always_comb begin
    gnt_en  = (state_reg == GRANTED);
    busy    = (state_reg == GRANTED);
    gnt_idx = idx_reg;
  end

  sel_decode_3to8 u_sel_decode (
    .a  (idx_reg[2]),
    .b  (idx_reg[1]),
    .c  (idx_reg[0]),
    .en (gnt_en),
    .y  (gnt_onehot)
  );

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Self-checking bench for decoder_grant_arbiter: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_decoder_grant_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_HOLD = 4;
  localparam bit TO_EN   = 1'b1;
`else
  localparam int TB_HOLD = 15;
  localparam bit TO_EN   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_en;
  logic [7:0] gnt_onehot;
  logic       busy;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;

  decoder_grant_arbiter #(.HOLD_MAX(TB_HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .gnt_idx    (gnt_idx),
    .gnt_en     (gnt_en),
    .gnt_onehot (gnt_onehot),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: one grant owner at a time, a released grant always
  // leaves one idle cycle, and the next owner is the first requester after
  // the previous owner in circular order.
  int m_en, m_idx, m_ptr, m_to, m_cnt;

  function automatic int next_owner(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      int j;
      j = (last + k) % 8;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  initial begin
    m_en = 0; m_idx = 0; m_ptr = 7; m_to = 0; m_cnt = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_en = 0; m_idx = 0; m_ptr = 7; m_to = 0; m_cnt = 0;
      end else begin
        m_to = 0;
        if (m_en != 0) begin
          if (done) begin
            m_en = 0;
          end else if (TO_EN && m_cnt == TB_HOLD - 1) begin
            m_en = 0;
            m_to = 1;
          end else begin
            m_cnt++;
          end
        end else if (req != 8'h00) begin
          m_idx = next_owner(req, m_ptr);
          m_ptr = m_idx;
          m_en  = 1;
          m_cnt = 0;
        end
      end
      #1;
      check("gnt_en", {7'd0, gnt_en}, 8'(m_en));
      check("busy", {7'd0, busy}, 8'(m_en));
      check("gnt_idx", {5'd0, gnt_idx}, 8'(m_idx));
      check("gnt_onehot", gnt_onehot, (m_en != 0) ? (8'd1 << m_idx) : 8'h00);
      check("timeout", {7'd0, timeout}, 8'(m_to));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_gnt_en", {7'd0, gnt_en}, 8'h00);
    check("rst_gnt_idx", {5'd0, gnt_idx}, 8'h00);
    check("rst_onehot", gnt_onehot, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_timeout", {7'd0, timeout}, 8'h00);
    reset = 1'b0;

    // Single request
    req = 8'h01;
    tick();
    check("single_en", {7'd0, gnt_en}, 8'h01);
    check("single_idx", {5'd0, gnt_idx}, 8'h00);
    check("single_onehot", gnt_onehot, 8'h01);
    req  = 8'h00;
    done = 1'b1;
    tick();
    check("single_gap", gnt_onehot, 8'h00);
    done = 1'b0;
    tick();
    check("single_idle", {7'd0, gnt_en}, 8'h00);

    // Full contention after reset: order 0..7,0 with one zero cycle between
    do_reset();
    req = 8'hFF;
    for (int g = 0; g <= 8; g++) begin
      tick();
      check($sformatf("rr_idx%0d", g), {5'd0, gnt_idx}, 8'(g % 8));
      check($sformatf("rr_en%0d", g), {7'd0, gnt_en}, 8'h01);
      tick();
      done = 1'b1;
      tick();
      check($sformatf("rr_gap%0d", g), gnt_onehot, 8'h00);
      done = 1'b0;
    end
    req = 8'h00;
    tick();

    // Rotation: after granting 2, req = 8'h84 gives 7 then 2
    do_reset();
    req = 8'h04;
    tick();
    check("rot_first", {5'd0, gnt_idx}, 8'h02);
    req  = 8'h84;
    done = 1'b1;
    tick();
    check("rot_gap1", gnt_onehot, 8'h00);
    done = 1'b0;
    tick();
    check("rot_second", {5'd0, gnt_idx}, 8'h07);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("rot_third", {5'd0, gnt_idx}, 8'h02);
    check("rot_third_oh", gnt_onehot, 8'h04);
    req  = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;

    // Reset mid-grant and re-issue
    req = 8'h20;
    tick();
    check("mid_idx", {5'd0, gnt_idx}, 8'h05);
    reset = 1'b1;
    tick();
    check("mid_rst_en", {7'd0, gnt_en}, 8'h00);
    check("mid_rst_idx", {5'd0, gnt_idx}, 8'h00);
    check("mid_rst_to", {7'd0, timeout}, 8'h00);
    reset = 1'b0;
    tick();
    check("mid_regrant", gnt_onehot, 8'h20);
    req  = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // Forced release after 4 held cycles, then re-grant to 3
    do_reset();
    req = 8'h08;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("to_held%0d", c), gnt_onehot, 8'h08);
    end
    tick();
    check("to_drop_en", {7'd0, gnt_en}, 8'h00);
    check("to_pulse", {7'd0, timeout}, 8'h01);
    tick();
    check("to_regrant", gnt_onehot, 8'h08);
    check("to_pulse_end", {7'd0, timeout}, 8'h00);
    // done coincides with the limit: release without pulse
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    check("coin_en", {7'd0, gnt_en}, 8'h00);
    check("coin_pulse", {7'd0, timeout}, 8'h00);
    done = 1'b0;
    req  = 8'h00;
    tick();
`else
    // Without the timeout feature a grant is held indefinitely
    do_reset();
    req = 8'h08;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check("hold_onehot", gnt_onehot, 8'h08);
      check("hold_timeout", {7'd0, timeout}, 8'h00);
    end
    req  = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       req = 8'h00;
        1:       req = 8'(1 << $urandom_range(0, 7));
        default: req = 8'($urandom);
      endcase
      done  = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder_grant_arbiter.md
# decoder_grant_arbiter

8-way round-robin arbiter that shares one 3-to-8 decoded select among eight requesters. It produces the decoder's 3-bit address and enable, plus the registered one-hot select that the decoder's Y7..Y0 outputs would give. It enforces break-before-make: after every release there is at least one cycle with all select lines low. It sits between requesting agents and the shared decode/select path, and sequences it.

## Interface
- HOLD_MAX, 15: maximum cycles a grant may be held without `done` (used only with timeout compiled in); legal range 1..255.
- clk  in  1  the only clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  8  request vector; bit i = requester i.
- done  in  1  release strobe from the current grantee; ignored unless a grant is active.
- gnt_idx  out  3  decoder address; gnt_idx[2] drives A, [1] drives B, [0] drives C; Y index = {A,B,C}.
- gnt_en  out  1  decoder enable; high exactly while a grant is active.
- gnt_onehot  out  8  gnt_en ? (1 << gnt_idx) : 8'h00; combinational from registered state.
- busy  out  1  high in GRANTED state (equal to gnt_en).
- timeout  out  1  one-cycle pulse on forced release (tied 0 without timeout feature).

## Operation
- States: IDLE, GRANTED, GAP.
- IDLE: if req != 0, select the winner, load gnt_idx, set gnt_en = 1, update ptr = winner, go to GRANTED. Otherwise stay in IDLE.
- Winner rule: the first set bit of req, searching ptr+1, ptr+2, ... mod 8.
- GRANTED: gnt_idx and gnt_en are held. Changes to req, including the grantee dropping its request, are ignored. On done = 1: gnt_en goes 0 and the state goes to GAP.
- GAP: gnt_en = 0 and gnt_idx holds its last value. The arbitration is the same as in IDLE. A win goes to GRANTED; otherwise the next state is IDLE.
- Reset values: state IDLE, ptr = 3'd7 (the first search starts at 0), gnt_idx = 3'd0, gnt_en = 0, gnt_onehot = 8'h00, busy = 0, timeout = 0, hold counter = 0.
- Fairness: a continuously requesting agent waits at most 7 grants.

## Timing
- Request to grant: req sampled at edge k gives gnt_en high after edge k (1-cycle latency).
- Release: done sampled high at edge n gives gnt_en low after edge n.
- Back-to-back handover: the next grant is active after edge n+1. Minimum gap is exactly one cycle with gnt_onehot = 0.
- Minimum grant length is 1 cycle (done high in the first GRANTED cycle).
- gnt_onehot and gnt_idx change only at clock edges. They never change while gnt_en is high.
- Reset mid-grant: the reset edge forces the reset values. No GAP cycle and no timeout pulse.
- done asserted in IDLE or GAP: no effect.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant and increments each GRANTED cycle.
  - If gnt_en has been high HOLD_MAX cycles with no done, gnt_en drops at the next edge and the block enters GAP.
  - timeout pulses high for that first GAP cycle.
  - If done and the limit coincide, done wins and no timeout pulse is produced.
- Undefined: no counter. A grant is held until done indefinitely, and timeout is constant 0.

## Structure
- Package arb_pkg:
  - state enum (IDLE, GRANTED, GAP);
  - NUM_REQ = 8;
  - IDX_W = 3;
  - CNT_W = 8.
- Sub-module sel_decode_3to8: purely combinational (a, b, c, en) to y[7:0], with y = en ? 1 << {a,b,c} : 0. It produces gnt_onehot.
- Winner search is a rotate-then-priority-encode function in the top module.

## Test plan
- Single request: reset, then req = 8'h01 → next cycle gnt_en = 1, gnt_idx = 0, gnt_onehot = 8'h01. done for 1 cycle → gnt_onehot = 8'h00 for one cycle, then IDLE.
- Full contention: req = 8'hFF held, done pulsed 2 cycles after each grant → grant order 0,1,...,7,0, with exactly one zero cycle between grants.
- Rotation: after granting 2, set req = 8'h84 → grants 7, then 2.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX = 4), req = 8'h08, done never → gnt_en high 4 cycles, then low with timeout = 1 for one cycle, then re-grant to 3.
- Timeout coincidence (ARB_TIMEOUT_EN, HOLD_MAX = 4): done on the 4th held cycle → release with timeout = 0.
- Reset in GRANTED with gnt_idx = 5 → next cycle all outputs at reset values. With req = 8'h20 still high, grant 5 is re-issued one cycle after reset deasserts.
